// File: rtl/riscv_cache_writeback.sv
// riscv_cache_writeback
//
// Write-back (evict) engine for the data cache. It takes one dirty line from the
// cache memory's evict buffer and sends it to the BIU as one write burst, one
// XLEN-bit beat per data acknowledge. Beats go out in linear order from the
// block-aligned base address. There is no critical-word-first ordering.
//
// Parameters
//   XLEN        data-beat width in bits (BIU data width)
//   PLEN        physical address width in bits
//   BLOCK_SIZE  cache block size in bytes; BEATS = 8*BLOCK_SIZE/XLEN (1,4,8,16)
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   evict_req_i     a line is presented on evict_adr_i/evict_q_i, held until evict_ack_o
//   evict_adr_i     line address; offset bits are ignored
//   evict_q_i       line data; bits [XLEN-1:0] hold the lowest address
//   evict_ack_o     1-cycle pulse: line captured, evict buffer may be reused
//   busy_o          a captured line is waiting for or in transit to the BIU
//   done_o          1-cycle pulse: final beat acknowledged by the BIU
//   err_o           1-cycle pulse: BIU error, burst aborted and line dropped
//   biu_stb_o       BIU request strobe (address phase)
//   biu_stb_ack_i   BIU accepted the request
//   biu_d_ack_i     BIU accepted the current data beat
//   biu_err_i       BIU error response
//   biu_adri_o      burst start address, block aligned
//   biu_we_o        write enable, high with biu_stb_o
//   biu_size_o      transfer size code (word / dword)
//   biu_type_o      burst type code (SINGLE / INCR4 / INCR8 / INCR16)
//   biu_d_o         current write beat
module riscv_cache_writeback #(
  parameter int XLEN       = 32,
  parameter int PLEN       = XLEN,
  parameter int BLOCK_SIZE = XLEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    evict_req_i,
  input  logic [PLEN-1:0]         evict_adr_i,
  input  logic [8*BLOCK_SIZE-1:0] evict_q_i,
  output logic                    evict_ack_o,

  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,

  output logic                    biu_stb_o,
  input  logic                    biu_stb_ack_i,
  input  logic                    biu_d_ack_i,
  input  logic                    biu_err_i,
  output logic [PLEN-1:0]         biu_adri_o,
  output logic                    biu_we_o,
  output logic [2:0]              biu_size_o,
  output logic [2:0]              biu_type_o,
  output logic [XLEN-1:0]         biu_d_o
);

  localparam int BLK_BITS = 8 * BLOCK_SIZE;
  localparam int BEATS    = BLK_BITS / XLEN;
  localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_BITS-1:0] LAST_BEAT   = CNT_BITS'(BEATS - 1);
  localparam logic [PLEN-1:0]     OFFSET_MASK = PLEN'(BLOCK_SIZE - 1);

  localparam logic [2:0] SIZE_CODE = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [2:0] TYPE_CODE = (BEATS == 16) ? 3'b100 :
                                     (BEATS == 8)  ? 3'b011 :
                                     (BEATS == 4)  ? 3'b010 : 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [PLEN-1:0]     adr_q;
  logic [XLEN-1:0]     beat_q [BEATS];
  logic                capture;

  // Next-state and handshake logic.
  // The BIU error has priority over every acknowledge. A d_ack in REQ counts only
  // when it arrives together with stb_ack. The counter advances only while it is
  // below the last beat, so it cannot wrap inside a burst.
  // evict_ack_o is gated with rst_ni so that it stays low during reset even when
  // a request is already pending.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    evict_ack_o = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    biu_stb_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (evict_req_i && rst_ni) begin
          capture     = 1'b1;
          evict_ack_o = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end

      REQ: begin
        biu_stb_o = 1'b1;
        if (biu_err_i) begin
          err_o   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (biu_stb_ack_i) begin
          if (biu_d_ack_i) begin
            if (BEATS == 1) begin
              done_o  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (biu_err_i) begin
          err_o   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (biu_d_ack_i) begin
          if (cnt_q == LAST_BEAT) begin
            done_o  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Line capture. The offset bits are cleared here so that the address is aligned
  // for the whole burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_q <= '0;
      for (int i = 0; i < BEATS; i++) begin
        beat_q[i] <= '0;
      end
    end else if (capture) begin
      adr_q <= evict_adr_i & ~OFFSET_MASK;
      for (int i = 0; i < BEATS; i++) begin
        beat_q[i] <= evict_q_i[i*XLEN +: XLEN];
      end
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign biu_we_o   = biu_stb_o;
  assign biu_adri_o = adr_q;
  assign biu_size_o = busy_o ? SIZE_CODE : 3'b000;
  assign biu_type_o = busy_o ? TYPE_CODE : 3'b000;

  // cnt_q is 0 in REQ, so beat 0 is presented during the address phase.
  if (BEATS == 1) begin : g_single
    assign biu_d_o = beat_q[0];
  end else begin : g_multi
    assign biu_d_o = beat_q[cnt_q];
  end

endmodule

// File: tb/tb_riscv_cache_writeback.sv
// tb_riscv_cache_writeback
//
// Bench for riscv_cache_writeback with XLEN=32 and BLOCK_SIZE=16 (four beats).
// Each request queues its expected beats in a scoreboard. A monitor on the
// falling edge compares the presented beat with the head of the queue and pops
// the head whenever the BIU accepts a beat.
module tb_riscv_cache_writeback;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         evict_req_i;
  logic [31:0]  evict_adr_i;
  logic [127:0] evict_q_i;
  logic         evict_ack_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic         biu_stb_o;
  logic         biu_stb_ack_i;
  logic         biu_d_ack_i;
  logic         biu_err_i;
  logic [31:0]  biu_adri_o;
  logic         biu_we_o;
  logic [2:0]   biu_size_o;
  logic [2:0]   biu_type_o;
  logic [31:0]  biu_d_o;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic        last;
  } exp_beat_t;

  exp_beat_t exp_q[$];
  int        checks = 0;
  int        errors = 0;
  bit        done_seen;

  riscv_cache_writeback #(
    .XLEN      (32),
    .PLEN      (32),
    .BLOCK_SIZE(16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .evict_req_i  (evict_req_i),
    .evict_adr_i  (evict_adr_i),
    .evict_q_i    (evict_q_i),
    .evict_ack_o  (evict_ack_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .biu_stb_o    (biu_stb_o),
    .biu_stb_ack_i(biu_stb_ack_i),
    .biu_d_ack_i  (biu_d_ack_i),
    .biu_err_i    (biu_err_i),
    .biu_adri_o   (biu_adri_o),
    .biu_we_o     (biu_we_o),
    .biu_size_o   (biu_size_o),
    .biu_type_o   (biu_type_o),
    .biu_d_o      (biu_d_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pushLine(input logic [31:0] adr, input logic [127:0] q);
    exp_beat_t e;
    for (int i = 0; i < 4; i++) begin
      e.adr  = adr & ~32'hF;
      e.data = q[i*32 +: 32];
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_evict_ack"}, evict_ack_o, 0);
    checkOutput({tag, "_busy"},      busy_o,      0);
    checkOutput({tag, "_done"},      done_o,      0);
    checkOutput({tag, "_err"},       err_o,       0);
    checkOutput({tag, "_stb"},       biu_stb_o,   0);
    checkOutput({tag, "_we"},        biu_we_o,    0);
    checkOutput({tag, "_size"},      biu_size_o,  0);
    checkOutput({tag, "_type"},      biu_type_o,  0);
    checkOutput({tag, "_adri"},      biu_adri_o,  0);
    checkOutput({tag, "_d"},         biu_d_o,     0);
  endtask

  // Presents a line, queues its beats and waits (bounded) for the capture pulse.
  // Returns at posedge+1 of the first REQ cycle.
  task automatic applyStimulus(input logic [31:0] adr, input logic [127:0] q);
    int guard = 0;
    evict_req_i = 1'b1;
    evict_adr_i = adr;
    evict_q_i   = q;
    pushLine(adr, q);
    @(negedge clk_i);
    while (!evict_ack_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("evict_ack", evict_ack_o, 1);
    checkOutput("busy_at_ack", busy_o, 0);
    tick();
    evict_req_i = 1'b0;
  endtask

  // BIU responder: it holds stb_ack low for stb_wait cycles and then plays the
  // d_ack pattern, with stb_ack raised together with the first pattern bit.
  task automatic driveBiu(input int stb_wait, input logic [15:0] acks, input int nacks);
    int guard = 0;
    while (!biu_stb_o && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("stb_start", biu_stb_o, 1);
    if (biu_stb_o) begin
      for (int i = 0; i < stb_wait; i++) begin
        biu_stb_ack_i = 1'b0;
        biu_d_ack_i   = 1'b0;
        @(negedge clk_i);
        checkOutput("stb_hold", biu_stb_o, 1);
        tick();
      end
      for (int i = 0; i < nacks; i++) begin
        biu_stb_ack_i = (i == 0);
        biu_d_ack_i   = acks[i];
        tick();
      end
      biu_stb_ack_i = 1'b0;
      biu_d_ack_i   = 1'b0;
      @(negedge clk_i);
      checkOutput("idle_after", busy_o, 0);
    end
  endtask

  // Scoreboard monitor
  initial begin : monitor
    exp_beat_t e;
    logic      accepted;
    forever begin
      @(negedge clk_i);
      if (rst_ni && busy_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL beat_queue: busy with no expected beat, d_o %0h at %0t",
                   biu_d_o, $time);
        end else begin
          e = exp_q[0];
          checkOutput("d_o", biu_d_o, e.data);
          if (biu_stb_o) begin
            checkOutput("adri", biu_adri_o, e.adr);
            checkOutput("we",   biu_we_o,   1'b1);
            checkOutput("type", biu_type_o, 3'b010);
            checkOutput("size", biu_size_o, 3'b010);
          end
          accepted = biu_d_ack_i && !biu_err_i && (!biu_stb_o || biu_stb_ack_i);
          if (accepted) begin
            checkOutput("done_on_beat", done_o, e.last);
            void'(exp_q.pop_front());
          end else begin
            checkOutput("done_no_beat", done_o, 1'b0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rst_ni        = 1'b0;
    evict_req_i   = 1'b1;
    evict_adr_i   = 32'h0000_1234;
    evict_q_i     = '1;
    biu_stb_ack_i = 1'b0;
    biu_d_ack_i   = 1'b0;
    biu_err_i     = 1'b0;

    // Reset state, with a request already pending
    #12;
    checkAllZero("reset");
    evict_req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: basic evict, zero-wait BIU
    $display("[TB] test 1 basic evict");
    applyStimulus(32'h0000_1234, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    @(negedge clk_i);
    checkOutput("t1_busy", busy_o, 1);
    checkOutput("t1_adri", biu_adri_o, 32'h0000_1230);
    checkOutput("t1_type", biu_type_o, 3'b010);
    checkOutput("t1_we",   biu_we_o, 1);
    checkOutput("t1_d0",   biu_d_o, 32'h1111_1111);
    tick();
    driveBiu(0, 16'h000F, 4);
    tick();

    // 2: stb_ack delayed by 5 cycles
    $display("[TB] test 2 delayed stb_ack");
    applyStimulus(32'h0000_4ABC, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    driveBiu(5, 16'h000F, 4);
    tick();

    // 3: d_ack pattern 1,0,0,1,1,0,1
    $display("[TB] test 3 toggled d_ack");
    applyStimulus(32'h0000_500F, 128'hCAFE_0003_CAFE_0002_CAFE_0001_CAFE_0000);
    driveBiu(0, 16'h0059, 7);
    tick();

    // 4: second request raised during the burst
    $display("[TB] test 4 request while busy");
    applyStimulus(32'h0000_1234, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    evict_req_i = 1'b1;
    evict_adr_i = 32'h0000_2008;
    evict_q_i   = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    pushLine(32'h0000_2008, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    done_seen = 1'b0;
    fork
      driveBiu(0, 16'h000F, 4);
      begin
        for (int i = 0; i < 40 && !done_seen; i++) begin
          @(negedge clk_i);
          if (done_o) begin
            checkOutput("t4_ack_at_done", evict_ack_o, 0);
            done_seen = 1'b1;
          end else begin
            checkOutput("t4_ack_busy", evict_ack_o, 0);
          end
        end
        checkOutput("t4_done_seen", done_seen, 1);
        @(negedge clk_i);
        checkOutput("t4_ack_after_done", evict_ack_o, 1);
      end
    join
    tick();
    evict_req_i = 1'b0;
    driveBiu(0, 16'h000F, 4);
    tick();

    // 5: BIU error on beat 2
    $display("[TB] test 5 error on beat 2");
    applyStimulus(32'h0000_6004, 128'hDEAD_0003_DEAD_0002_DEAD_0001_DEAD_0000);
    biu_stb_ack_i = 1'b1;
    biu_d_ack_i   = 1'b1;
    tick();
    biu_stb_ack_i = 1'b0;
    tick();
    biu_d_ack_i = 1'b0;
    biu_err_i   = 1'b1;
    @(negedge clk_i);
    checkOutput("t5_err", err_o, 1);
    checkOutput("t5_no_done", done_o, 0);
    checkOutput("t5_d2", biu_d_o, 32'hDEAD_0002);
    tick();
    biu_err_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    checkOutput("t5_err_cleared", err_o, 0);
    checkOutput("t5_busy", busy_o, 0);
    checkOutput("t5_stb", biu_stb_o, 0);
    tick();
    applyStimulus(32'h0000_7000, 128'h7777_0003_7777_0002_7777_0001_7777_0000);
    driveBiu(0, 16'h000F, 4);
    tick();

    // 6: reset during DATA beat 1
    $display("[TB] test 6 reset mid-burst");
    applyStimulus(32'h0000_8010, 128'h8888_0003_8888_0002_8888_0001_8888_0000);
    biu_stb_ack_i = 1'b1;
    biu_d_ack_i   = 1'b1;
    tick();
    biu_stb_ack_i = 1'b0;
    biu_d_ack_i   = 1'b0;
    #1;
    checkOutput("t6_beat1", biu_d_o, 32'h8888_0001);
    #1;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    checkAllZero("t6_reset");
    tick();
    rst_ni = 1'b1;
    tick();
    applyStimulus(32'h0000_9000, 128'h9999_0003_9999_0002_9999_0001_9999_0000);
    @(negedge clk_i);
    checkOutput("t6_restart_d0", biu_d_o, 32'h9999_0000);
    tick();
    driveBiu(0, 16'h000F, 4);
    tick();

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
